input_controller: RTL and testbench
===================================

Name: input_controller

Overview:
- AXI4-Stream slave front end of the polar decoder. Receives one frame of INPUT_LENGTH channel LLR words and writes them sequentially into the input-buffer BRAM.
- Active only while the top-level FSM holds state==INPUT_STATE.
- Raises input_done when the frame is committed, so the top FSM can advance to decoding.
- Mirror of the output stage: stream-to-BRAM instead of BRAM-to-stream.

Parameters:
- INPUT_LENGTH, 1024: LLR words per frame.
- ADDR_WIDTH, 10: input-buffer BRAM address width.
- DATA_WIDTH, 8: LLR word width (stream data and BRAM data).
- STATE_WIDTH, 8: width of the top-level state bus.
- INPUT_STATE, 8'd1: top-level state code in which reception is enabled.
- INNER_COUNTER_WIDTH, 11: beat counter width; must be able to hold INPUT_LENGTH.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- state  in  STATE_WIDTH  top-level FSM state.
- saxis_tdata  in  DATA_WIDTH  incoming LLR word.
- saxis_tvalid  in  1  upstream data valid.
- saxis_tlast  in  1  last beat of frame.
- saxis_tready  out  1  ready to accept a beat.
- data_to_bram  out  DATA_WIDTH  BRAM write data.
- addr_to_bram  out  ADDR_WIDTH  BRAM write address.
- write_enable_to_bram  out  1  BRAM write strobe.
- input_done  out  1  frame committed; level signal.
- length_error  out  1  last frame had wrong length (sticky).

Behaviour:
- Reset (reset_n=0, async): FSM=IDLE, counter=0. All outputs are 0: saxis_tready, data_to_bram, addr_to_bram, write_enable_to_bram, input_done, length_error.
- FSM states are IDLE, RECEIVE, DRAIN, DONE. saxis_tready is decoded combinationally from FSM: 1 in RECEIVE and DRAIN, 0 otherwise.
- A beat is accepted when saxis_tvalid & saxis_tready.
- IDLE -> RECEIVE: when state==INPUT_STATE. On entry, counter=0 and length_error is cleared.
- RECEIVE, each accepted beat:
  - Registered write: next cycle write_enable_to_bram=1, addr_to_bram=counter[ADDR_WIDTH-1:0], data_to_bram=saxis_tdata.
  - Counter +1. Write latency is 1 cycle; writes are never reordered.
- Beat accepted with counter==INPUT_LENGTH-1 and tlast=1: go to DONE (normal end).
- Beat accepted with counter==INPUT_LENGTH-1 and tlast=0: overlong frame. Set length_error=1 and go to DRAIN.
- Beat accepted with tlast=1 and counter<INPUT_LENGTH-1: short frame. Set length_error=1 and go to DONE. Unwritten addresses keep their old contents.
- DRAIN: accept and discard beats (no BRAM write) until a beat with tlast=1 is accepted, then go to DONE.
- DONE:
  - input_done is registered. It rises the cycle after the final write_enable_to_bram pulse, or the cycle after entering DONE from DRAIN.
  - It stays high while state==INPUT_STATE.
  - When state!=INPUT_STATE: input_done falls next edge, FSM goes to IDLE, counter=0.
- Abort: state leaves INPUT_STATE while in RECEIVE or DRAIN.
  - Go to IDLE next edge; counter=0; no input_done.
  - length_error keeps its value.
  - A write already registered still completes.
- write_enable_to_bram is a single-cycle strobe per accepted beat. It is 0 in every other cycle.
- Idle cycles (tvalid=0) in RECEIVE hold the counter and produce no write.
- Simultaneous abort and accepted beat: the beat is written, then the FSM aborts.

Decomposition:
- Shared package `polar_pkg`:
  - top-level state codes (INPUT_STATE etc.), so the input, output and top FSM agree;
  - LLR width constant;
  - `in_fsm_t` enum for IDLE/RECEIVE/DRAIN/DONE.
- No sub-module. A single module holds the FSM, the beat counter and the write register stage.

Test Plan:
- Nominal frame: state=INPUT_STATE, 1024 beats with tdata=i[7:0] and tlast on beat 1023 -> 1024 write strobes at addr 0..1023 with data i[7:0], each 1 cycle after its beat. input_done=1 the cycle after the last write. length_error=0.
- Backpressure gaps: same frame with tvalid toggled 1/0 randomly -> identical BRAM contents, no duplicate or missing addresses. Counter holds during gaps.
- Short frame: tlast on beat 99 -> writes to addr 0..99 only. length_error=1 and input_done=1. Then state changes -> input_done=0 and FSM=IDLE.
- Long frame: 1030 beats, tlast on beat 1029 -> writes to addr 0..1023 only. Beats 1024..1029 accepted with no write. length_error=1, then input_done=1.
- Abort and reset:
  - state leaves INPUT_STATE after 500 beats -> tready=0 next cycle, input_done stays 0. Re-entering INPUT_STATE restarts writes at addr 0.
  - reset_n pulsed low mid-frame -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/polar_pkg.sv
// polar_pkg: constants and types shared by the polar decoder's top FSM and its I/O stages.
// Revision 1.0
`default_nettype none

package polar_pkg;

    localparam int STATE_WIDTH = 8;
    localparam int LLR_WIDTH   = 8;

    localparam logic [STATE_WIDTH-1:0] IDLE_STATE   = 8'd0;
    localparam logic [STATE_WIDTH-1:0] INPUT_STATE  = 8'd1;
    localparam logic [STATE_WIDTH-1:0] DECODE_STATE = 8'd2;
    localparam logic [STATE_WIDTH-1:0] OUTPUT_STATE = 8'd3;

    typedef enum logic [1:0] {
        IN_IDLE    = 2'd0,
        IN_RECEIVE = 2'd1,
        IN_DRAIN   = 2'd2,
        IN_DONE    = 2'd3
    } in_fsm_t;

endpackage

`default_nettype wire

// File: rtl/input_controller.sv
// input_controller: AXI4-Stream slave that writes one frame of LLR words into the input BRAM.
// Revision 1.0
`default_nettype none

module input_controller #(
    parameter int INPUT_LENGTH        = 1024,
    parameter int ADDR_WIDTH          = 10,
    parameter int DATA_WIDTH          = polar_pkg::LLR_WIDTH,
    parameter int STATE_WIDTH         = polar_pkg::STATE_WIDTH,
    parameter logic [STATE_WIDTH-1:0] INPUT_STATE = polar_pkg::INPUT_STATE,
    parameter int INNER_COUNTER_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [STATE_WIDTH-1:0] state,
    input  logic [DATA_WIDTH-1:0]  saxis_tdata,
    input  logic                   saxis_tvalid,
    input  logic                   saxis_tlast,
    output logic                   saxis_tready,
    output logic [DATA_WIDTH-1:0]  data_to_bram,
    output logic [ADDR_WIDTH-1:0]  addr_to_bram,
    output logic                   write_enable_to_bram,
    output logic                   input_done,
    output logic                   length_error
);

    import polar_pkg::*;

    localparam logic [INNER_COUNTER_WIDTH-1:0] c_LAST = INNER_COUNTER_WIDTH'(INPUT_LENGTH - 1);

    in_fsm_t                        r_fsm;
    in_fsm_t                        w_next_fsm;
    logic [INNER_COUNTER_WIDTH-1:0] r_counter;
    logic                           r_we;
    logic [ADDR_WIDTH-1:0]          r_addr;
    logic [DATA_WIDTH-1:0]          r_data;
    logic                           r_done;
    logic                           r_len_err;

    logic w_in_state;
    logic w_tready;
    logic w_accept;
    logic w_last_slot;
    logic w_write;
    logic w_inc;
    logic w_clr_cnt;
    logic w_set_err;
    logic w_clr_err;
    logic w_done_nxt;

    assign w_in_state  = (state == INPUT_STATE);
    assign w_tready    = (r_fsm == IN_RECEIVE) || (r_fsm == IN_DRAIN);
    assign w_accept    = saxis_tvalid & w_tready;
    assign w_last_slot = (r_counter == c_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm <= IN_IDLE;
        end else begin
            r_fsm <= w_next_fsm;
        end
    end

    always_comb begin
        w_next_fsm = r_fsm;
        w_write    = 1'b0;
        w_inc      = 1'b0;
        w_clr_cnt  = 1'b0;
        w_set_err  = 1'b0;
        w_clr_err  = 1'b0;
        w_done_nxt = 1'b0;
        case (r_fsm)
            IN_IDLE: begin
                if (w_in_state) begin
                    w_next_fsm = IN_RECEIVE;
                    w_clr_cnt  = 1'b1;
                    w_clr_err  = 1'b1;
                end
            end
            IN_RECEIVE: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    w_inc   = 1'b1;
                    if (w_last_slot) begin
                        if (saxis_tlast) begin
                            w_next_fsm = IN_DONE;
                        end else begin
                            w_set_err  = 1'b1;
                            w_next_fsm = IN_DRAIN;
                        end
                    end else if (saxis_tlast) begin
                        w_set_err  = 1'b1;
                        w_next_fsm = IN_DONE;
                    end
                end
                // An abort wins over the beat's state change, but the beat itself is still written.
                if (!w_in_state) begin
                    w_next_fsm = IN_IDLE;
                    w_clr_cnt  = 1'b1;
                end
            end
            IN_DRAIN: begin
                if (w_accept && saxis_tlast) begin
                    w_next_fsm = IN_DONE;
                end
                if (!w_in_state) begin
                    w_next_fsm = IN_IDLE;
                    w_clr_cnt  = 1'b1;
                end
            end
            IN_DONE: begin
                if (w_in_state) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_next_fsm = IN_IDLE;
                    w_clr_cnt  = 1'b1;
                end
            end
            default: begin
                w_next_fsm = IN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_counter <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_we   <= w_write;
            r_done <= w_done_nxt;
            if (w_write) begin
                r_addr <= r_counter[ADDR_WIDTH-1:0];
                r_data <= saxis_tdata;
            end
            if (w_clr_cnt) begin
                r_counter <= '0;
            end else if (w_inc) begin
                r_counter <= r_counter + 1'b1;
            end
            if (w_clr_err) begin
                r_len_err <= 1'b0;
            end else if (w_set_err) begin
                r_len_err <= 1'b1;
            end
        end
    end

    assign saxis_tready         = w_tready;
    assign data_to_bram         = r_data;
    assign addr_to_bram         = r_addr;
    assign write_enable_to_bram = r_we;
    assign input_done           = r_done;
    assign length_error         = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_input_controller.sv
// tb_input_controller: randomized frames checked against a frame-level model of the input stage.
// Revision 1.0
`default_nettype none

module tb_input_controller;
    import polar_pkg::*;

    localparam int LEN = 1024;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] state = 8'd0;
    logic [7:0] tdata = 8'd0;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       tready;
    logic [7:0] bram_data;
    logic [9:0] bram_addr;
    logic       bram_we;
    logic       done;
    logic       len_err;

    int compared = 0;
    int mismatched = 0;

    input_controller dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .state                (state),
        .saxis_tdata          (tdata),
        .saxis_tvalid         (tvalid),
        .saxis_tlast          (tlast),
        .saxis_tready         (tready),
        .data_to_bram         (bram_data),
        .addr_to_bram         (bram_addr),
        .write_enable_to_bram (bram_we),
        .input_done           (done),
        .length_error         (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"}, tready, 0);
        check({tag, "_data"}, bram_data, 0);
        check({tag, "_addr"}, bram_addr, 0);
        check({tag, "_we"}, bram_we, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_lenerr"}, len_err, 0);
    endtask

    // Sends an n-beat frame; beat i lands at address i only when i < LEN.
    // abort_at >= 0 drops the state on that beat (the beat itself is still offered).
    task automatic run_frame(input int n, input int gap_pct, input int abort_at, input bit rand_data);
        int         k;
        bit         v;
        bit         aborted;
        logic [7:0] d;
        k = 0;
        aborted = 1'b0;
        state = INPUT_STATE;
        @(posedge clk); #1;
        check("ready_on_entry", tready, 1);
        check("lenerr_cleared", len_err, 0);
        while (k < n && !aborted) begin
            d = rand_data ? 8'($urandom) : 8'(k);
            v = (abort_at == k) ? 1'b1 : ($urandom_range(99) >= gap_pct);
            tvalid = v;
            tdata  = d;
            tlast  = (k == n - 1);
            if (abort_at == k) begin
                state   = 8'd0;
                aborted = 1'b1;
            end
            check("tready_in_frame", tready, 1);
            @(posedge clk); #1;
            if (v && k < LEN) begin
                check("we_beat", bram_we, 1);
                check("addr_beat", bram_addr, 32'(k));
                check("data_beat", bram_data, 32'(d));
            end else begin
                check("we_idle", bram_we, 0);
            end
            if (v) k++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        if (aborted) begin
            check("abort_tready", tready, 0);
            check("abort_done", done, 0);
            check("abort_lenerr", len_err, 32'(abort_at >= LEN));
            @(posedge clk); #1;
            check("abort_we", bram_we, 0);
            check("abort_done2", done, 0);
            check("abort_tready2", tready, 0);
        end else begin
            check("done_not_early", done, 0);
            check("tready_after_last", tready, 0);
            @(posedge clk); #1;
            check("done_rise", done, 1);
            check("we_after_done", bram_we, 0);
            check("lenerr_frame", len_err, 32'(n != LEN));
            repeat (3) @(posedge clk);
            #1;
            check("done_hold", done, 1);
            state = 8'd0;
            @(posedge clk); #1;
            check("done_fall", done, 0);
            check("tready_idle", tready, 0);
            @(posedge clk); #1;
            check("idle_done", done, 0);
            check("idle_tready", tready, 0);
        end
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_ready", tready, 0);

        run_frame(1024, 0, -1, 1'b0);   // nominal
        run_frame(1024, 40, -1, 1'b1);  // random gaps
        run_frame(100, 20, -1, 1'b1);   // short
        run_frame(1030, 10, -1, 1'b1);  // long
        run_frame(1024, 20, 500, 1'b1); // abort in RECEIVE
        run_frame(600, 0, -1, 1'b0);    // restart from addr 0
        run_frame(1030, 0, 1026, 1'b1); // abort in DRAIN keeps length_error
        run_frame(1024, 25, -1, 1'b1);

        state = INPUT_STATE;
        for (int i = 0; i < 12; i++) begin
            tvalid = 1'b1;
            tdata  = 8'(i + 1);
            tlast  = 1'b0;
            @(posedge clk);
        end
        #1;
        check("pre_reset_we", bram_we, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tvalid = 1'b0;
        state  = 8'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_tready", tready, 0);

        run_frame(1024, 10, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
